// File: rtl/afu_pkg.sv
// Shared AFU definitions: cache-line width, sample/line count type and the
// result line packer state encoding.
package afu_pkg;

  localparam int unsigned CL_DATA_WIDTH = 512;
  localparam int unsigned COUNT_WIDTH   = 65;

  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } packer_state_e;

endpackage : afu_pkg

// File: rtl/result_line_packer_if.sv
// Data-path bundle for the result line packer: show-ahead sample FIFO read
// port plus the DMA write channel.
//   fifo_empty    FIFO has no head sample
//   fifo_rd_en    pop strobe, head data consumed in the same cycle
//   fifo_rd_data  FIFO head sample
//   wr_full       DMA write channel cannot accept a line
//   wr_en         wr_data is written this cycle
//   wr_data       packed cache line
// master = packer side, slave = FIFO/DMA side.
interface result_line_packer_if #(
  parameter int unsigned FIFO_WIDTH = 20,
  parameter int unsigned CL_WIDTH   = afu_pkg::CL_DATA_WIDTH
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] fifo_rd_data;
  logic                  wr_full;
  logic                  wr_en;
  logic [CL_WIDTH-1:0]   wr_data;

  modport master (
    input  fifo_empty, fifo_rd_data, wr_full,
    output fifo_rd_en, wr_en, wr_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, wr_full,
    input  fifo_rd_en, wr_en, wr_data
  );

endinterface : result_line_packer_if

// File: rtl/result_line_packer.sv
// Result line packer: drains a run of num_samples samples from a show-ahead
// FIFO, packs them into cache lines (slot 0 = earliest sample, each sample
// zero-extended to RESULT_WIDTH) and writes ceil(num_samples/RESULTS_PER_CL)
// lines to the DMA write channel, zero-padding the last partial line.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   go           run start, honoured only in IDLE or DONE
//   num_samples  samples in the run, captured on go
//   bus          FIFO read port + DMA write port (master modport)
//   wr_lines     line count of the run, registered on go
//   busy         run in progress
//   done         all lines written, held until the next go
// Build option: define PACKER_SEQ_TAG_EN to place the low
// (RESULT_WIDTH-FIFO_WIDTH) bits of each sample's run index in the slot bits
// above the sample; otherwise those bits are zero.
module result_line_packer
  import afu_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned FIFO_WIDTH   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  count_t               num_samples,
  result_line_packer_if.master bus,
  output count_t               wr_lines,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned RESULTS_PER_CL = CL_DATA_WIDTH / RESULT_WIDTH;
  localparam int unsigned IDX_W          = $clog2(RESULTS_PER_CL);
  localparam int unsigned SLOT_W         = $clog2(RESULTS_PER_CL + 1);
`ifdef PACKER_SEQ_TAG_EN
  localparam int unsigned TAG_W          = RESULT_WIDTH - FIFO_WIDTH;
`endif

  packer_state_e state_q, state_d;

  logic [RESULTS_PER_CL-1:0][RESULT_WIDTH-1:0] line_q;
  logic [SLOT_W-1:0]                           slot_q;
  count_t                                      remaining_q;

  logic              rd_en_c;
  logic              wr_en_c;
  logic              start_c;
  logic [SLOT_W-1:0] slot_nxt_c;
  count_t            rem_nxt_c;
  count_t            lines_c;
  logic [RESULT_WIDTH-1:0] word_c;

`ifdef PACKER_SEQ_TAG_EN
  logic [TAG_W-1:0] tag_q;
`endif

  // Line count without an adder carry-out: whole lines plus one for any remainder.
  assign lines_c = (num_samples >> IDX_W) + count_t'(|num_samples[IDX_W-1:0]);

  // Slot content for the current FIFO head.
`ifdef PACKER_SEQ_TAG_EN
  assign word_c = {tag_q, bus.fifo_rd_data[FIFO_WIDTH-1:0]};
`else
  assign word_c = RESULT_WIDTH'(bus.fifo_rd_data[FIFO_WIDTH-1:0]);
`endif

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.wr_en      = wr_en_c;
  assign bus.wr_data    = line_q;
  assign busy           = (state_q == FILL) || (state_q == WRITE);
  assign done           = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake strobes.
  always_comb begin
    state_d    = state_q;
    rd_en_c    = 1'b0;
    wr_en_c    = 1'b0;
    start_c    = 1'b0;
    slot_nxt_c = slot_q;
    rem_nxt_c  = remaining_q;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          start_c = 1'b1;
          state_d = (num_samples == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        rd_en_c    = !bus.fifo_empty && (remaining_q != '0) &&
                     (slot_q < SLOT_W'(RESULTS_PER_CL));
        slot_nxt_c = slot_q + SLOT_W'(rd_en_c);
        rem_nxt_c  = remaining_q - count_t'(rd_en_c);
        // Line is complete when full, or when the run ends on a partial line.
        if ((slot_nxt_c == SLOT_W'(RESULTS_PER_CL)) ||
            ((rem_nxt_c == '0) && (slot_nxt_c != '0))) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en_c = !bus.wr_full;
        if (wr_en_c) begin
          state_d = (remaining_q != '0) ? FILL : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line buffer, slot pointer and run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q      <= '0;
      slot_q      <= '0;
      remaining_q <= '0;
      wr_lines    <= '0;
`ifdef PACKER_SEQ_TAG_EN
      tag_q       <= '0;
`endif
    end else if (start_c) begin
      line_q      <= '0;
      slot_q      <= '0;
      remaining_q <= num_samples;
      wr_lines    <= lines_c;
`ifdef PACKER_SEQ_TAG_EN
      tag_q       <= '0;
`endif
    end else begin
      if (rd_en_c) begin
        line_q[slot_q[IDX_W-1:0]] <= word_c;
        slot_q                    <= slot_nxt_c;
        remaining_q               <= rem_nxt_c;
`ifdef PACKER_SEQ_TAG_EN
        tag_q                     <= tag_q + TAG_W'(1);
`endif
      end
      // Written line leaves the buffer; padding slots start at zero again.
      if (wr_en_c) begin
        line_q <= '0;
        slot_q <= '0;
      end
    end
  end

endmodule : result_line_packer

// File: tb/tb_result_line_packer.sv
// Self-checking bench for result_line_packer: a FIFO model feeds directed
// sample runs, expected lines go into a scoreboard queue and a monitor
// compares every DMA write against it.
module tb_result_line_packer;
  import afu_pkg::*;

  localparam int unsigned RW    = 32;
  localparam int unsigned FW    = 20;
  localparam int unsigned TW    = RW - FW;
  localparam int unsigned RPC   = CL_DATA_WIDTH / RW;
  localparam int unsigned DEPTH = 16384;

  logic   clk = 1'b0;
  logic   rst;
  logic   go;
  count_t num_samples;
  count_t wr_lines;
  logic   busy;
  logic   done;

  result_line_packer_if #(.FIFO_WIDTH(FW)) bus ();

  result_line_packer #(
    .RESULT_WIDTH(RW),
    .FIFO_WIDTH  (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .num_samples(num_samples),
    .bus        (bus),
    .wr_lines   (wr_lines),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model.
  logic [FW-1:0] fifo_mem [DEPTH];
  logic [13:0]   wr_ptr = '0;
  logic [13:0]   rd_ptr = '0;
  logic          flush  = 1'b0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;

  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_data = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 14'd1;
    if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (bus.wr_en) wr_cnt <= wr_cnt + 1;
  end

  logic [CL_DATA_WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted write must match the next expected line.
  always @(negedge clk) begin
    logic [CL_DATA_WIDTH-1:0] e;
    if (rst === 1'b0 && bus.wr_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL line_unexpected: got %h expected no write", bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_data === e) n_pass++;
        else $display("FAIL line_data: got %h expected %h", bus.wr_data, e);
      end
    end
  end

  function automatic logic [RW-1:0] mk_word(input logic [FW-1:0] v, input int idx);
`ifdef PACKER_SEQ_TAG_EN
    return {TW'(idx), v};
`else
    return RW'(v) | RW'(TW'(idx) & TW'(0));
`endif
  endfunction

  // Load n samples (base + step*i) into the FIFO; optionally queue expected lines.
  task automatic push_run(input int n, input int base, input int step, input bit with_exp);
    logic [CL_DATA_WIDTH-1:0] line;
    logic [FW-1:0]            v;
    int                       slot;
    line = '0;
    slot = 0;
    for (int i = 0; i < n; i++) begin
      v = FW'(base + step * i);
      fifo_mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 14'd1;
      line[slot*RW +: RW] = mk_word(v, i);
      slot++;
      if (slot == RPC) begin
        if (with_exp) exp_q.push_back(line);
        line = '0;
        slot = 0;
      end
    end
    if (slot != 0 && with_exp) exp_q.push_back(line);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input int n);
    num_samples = count_t'(n);
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check(name, 512'(done), 512'(1));
  endtask

  task automatic wait_reads(input string name, input int r0, input int target, input int budget);
    int c;
    c = 0;
    while ((rd_cnt - r0) < target && c < budget) begin
      tick();
      c++;
    end
    check(name, 512'(rd_cnt - r0), 512'(target));
  endtask

  initial begin
    int r0;
    int w0;
    logic [CL_DATA_WIDTH-1:0] d0;
    rst = 1'b1;
    go = 1'b0;
    num_samples = '0;
    bus.wr_full = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_wr_lines", 512'(wr_lines), 512'(0));
    check("rst_wr_data", 512'(bus.wr_data), 512'(0));
    check("rst_rd_en", 512'(bus.fifo_rd_en), 512'(0));
    check("rst_wr_en", 512'(bus.wr_en), 512'(0));
    rst = 1'b0;
    tick();

    // Empty run: done one cycle after go, no traffic.
    r0 = rd_cnt; w0 = wr_cnt;
    check("zero_done_before", 512'(done), 512'(0));
    pulse_go(0);
    check("zero_done", 512'(done), 512'(1));
    check("zero_busy", 512'(busy), 512'(0));
    check("zero_wr_lines", 512'(wr_lines), 512'(0));
    repeat (3) tick();
    check("zero_reads", 512'(rd_cnt - r0), 512'(0));
    check("zero_writes", 512'(wr_cnt - w0), 512'(0));

    // Two full lines: samples 0..31.
    push_run(32, 0, 1, 1'b1);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_go(32);
    check("full_wr_lines", 512'(wr_lines), 512'(2));
    check("full_busy", 512'(busy), 512'(1));
    check("full_done_cleared", 512'(done), 512'(0));
    wait_done("full_done", 100);
    check("full_writes", 512'(wr_cnt - w0), 512'(2));
    check("full_reads", 512'(rd_cnt - r0), 512'(32));
    check("full_busy_end", 512'(busy), 512'(0));

    // Partial last line: 20 samples, slots 4..15 of line 1 padded.
    push_run(20, 0, 1, 1'b1);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_go(20);
    check("part_wr_lines", 512'(wr_lines), 512'(2));
    wait_done("part_done", 100);
    check("part_writes", 512'(wr_cnt - w0), 512'(2));
    check("part_reads", 512'(rd_cnt - r0), 512'(20));

    // Write-channel stall: wr_data held, single write when wr_full drops.
    bus.wr_full = 1'b1;
    push_run(16, 'h100, 1, 1'b1);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_go(16);
    wait_reads("stall_reads", r0, 16, 50);
    d0 = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      check("stall_wr_en", 512'(bus.wr_en), 512'(0));
      check("stall_wr_data", bus.wr_data, d0);
      tick();
    end
    bus.wr_full = 1'b0;
    @(negedge clk);
    check("stall_release_wr_en", 512'(bus.wr_en), 512'(1));
    tick();
    check("stall_after_wr_en", 512'(bus.wr_en), 512'(0));
    check("stall_writes", 512'(wr_cnt - w0), 512'(1));
    check("stall_done", 512'(done), 512'(1));

    // Reset mid-run after 7 of 16 reads, then a clean run.
    push_run(16, 'h200, 1, 1'b0);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_go(16);
    wait_reads("abort_reads", r0, 7, 30);
    rst = 1'b1;
    flush = 1'b1;
    #1;
    check("abort_busy", 512'(busy), 512'(0));
    check("abort_done", 512'(done), 512'(0));
    check("abort_wr_en", 512'(bus.wr_en), 512'(0));
    check("abort_rd_en", 512'(bus.fifo_rd_en), 512'(0));
    tick();
    flush = 1'b0;
    check("abort_wr_data", 512'(bus.wr_data), 512'(0));
    rst = 1'b0;
    tick();
    push_run(16, 'h300, 1, 1'b1);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_go(16);
    check("clean_wr_lines", 512'(wr_lines), 512'(1));
    wait_done("clean_done", 60);
    check("clean_writes", 512'(wr_cnt - w0), 512'(1));
    check("clean_reads", 512'(rd_cnt - r0), 512'(16));

`ifdef PACKER_SEQ_TAG_EN
    // Run index wraps at 2^TW; last line carries indices 0..15 again.
    push_run(4096 + 16, 0, 0, 1'b1);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_go(4096 + 16);
    check("tag_wr_lines", 512'(wr_lines), 512'(257));
    wait_done("tag_done", 6000);
    check("tag_writes", 512'(wr_cnt - w0), 512'(257));
`endif

    tick();
    check("scoreboard_drained", 512'(exp_q.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_result_line_packer
